// File: rtl/alu_operand_stage_pkg.sv
// Shared constants for the ALU issue path: widths, register-zero
// address and the ALU opcode encoding used by the stage and the ALU.
package alu_operand_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 4;
    localparam int OPC_W  = 4;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef enum logic [OPC_W-1:0] {
        ALU_OR     = 4'd0,
        ALU_AND    = 4'd1,
        ALU_XOR    = 4'd2,
        ALU_ADD    = 4'd3,
        ALU_SUB    = 4'd4,
        ALU_SHIFTL = 4'd5,
        ALU_SHIFTR = 4'd6,
        ALU_MULT   = 4'd7,
        ALU_NOTA   = 4'd8
    } alu_op_e;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Combinational operand resolve for one source register.
// Ports: src address, EX/WB forward taps, bank read data -> data.
module operand_fwd_mux
    import alu_operand_stage_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic              ex_we,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] data
);

    // r0 is hardwired, so a match on it never forwards;
    // the younger EX result wins over WB.
    always_comb begin
        data = rf_data;
        if (src == REG_ZERO) begin
            data = '0;
        end else if (ex_we && ex_rd == src) begin
            data = ex_data;
        end else if (wb_we && wb_rd == src) begin
            data = wb_data;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Issue stage feeding the ALU: operand forwarding, load-use stall,
// registered ALU inputs with valid/ready on both sides and flush.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic              in_skip,
    input  logic              in_sig,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_we,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
    output logic [REG_AW-1:0] rf_addr_a,
    output logic [REG_AW-1:0] rf_addr_b,
    input  logic [DATA_W-1:0] rf_data_a,
    input  logic [DATA_W-1:0] rf_data_b,
    input  logic              ex_we,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              ex_pending,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic              alu_skip,
    output logic              alu_sig,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_we
);

    logic              need_a;
    logic              need_b;
    logic              hazard;
    logic              load;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] b_next;

    assign rf_addr_a = in_rs1;
    assign rf_addr_b = in_rs2;

    operand_fwd_mux u_fwd_a (
        .src     (in_rs1),
        .ex_we   (ex_we),
        .ex_rd   (ex_rd),
        .ex_data (ex_data),
        .wb_we   (wb_we),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .rf_data (rf_data_a),
        .data    (fwd_a)
    );

    operand_fwd_mux u_fwd_b (
        .src     (in_rs2),
        .ex_we   (ex_we),
        .ex_rd   (ex_rd),
        .ex_data (ex_data),
        .wb_we   (wb_we),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .rf_data (rf_data_b),
        .data    (fwd_b)
    );

    assign need_a = !in_skip;
    assign need_b = !in_use_imm;
    assign b_next = in_use_imm ? in_imm : fwd_b;

    // Stall only when an operand actually consumed is still
    // being loaded by the instruction in EX.
    assign hazard = in_valid && ex_we && ex_pending
                 && (ex_rd != REG_ZERO)
                 && ((need_a && ex_rd == in_rs1)
                  || (need_b && ex_rd == in_rs2));

    assign in_ready = !flush && !hazard
                   && (!out_valid || out_ready);

    assign load = in_valid && in_ready;

    // Data fields only move on a load, so a downstream stall
    // keeps every output bit-stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            alu_skip   <= 1'b0;
            alu_sig    <= 1'b0;
            out_rd     <= '0;
            out_we     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid  <= 1'b1;
            alu_a      <= fwd_a;
            alu_b      <= b_next;
            alu_opcode <= in_opcode;
            alu_skip   <= in_skip;
            alu_sig    <= in_sig;
            out_rd     <= in_rd;
            out_we     <= in_we;
        end else if (out_ready || !out_valid) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed scenarios plus
// randomized traffic against a register-view reference model.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_opcode = '0;
    logic        in_skip = 1'b0;
    logic        in_sig = 1'b0;
    logic [3:0]  in_rs1 = '0;
    logic [3:0]  in_rs2 = '0;
    logic [3:0]  in_rd = '0;
    logic        in_we = 1'b0;
    logic        in_use_imm = 1'b0;
    logic [31:0] in_imm = '0;
    logic [3:0]  rf_addr_a;
    logic [3:0]  rf_addr_b;
    logic [31:0] rf_data_a;
    logic [31:0] rf_data_b;
    logic        ex_we = 1'b0;
    logic [3:0]  ex_rd = '0;
    logic [31:0] ex_data = '0;
    logic        ex_pending = 1'b0;
    logic        wb_we = 1'b0;
    logic [3:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_opcode;
    logic        alu_skip;
    logic        alu_sig;
    logic [3:0]  out_rd;
    logic        out_we;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        skip;
        logic        sig;
        logic [3:0]  rd;
        logic        we;
    } exp_t;

    logic [31:0] rf_mem [16];
    exp_t        q [$];
    int          total = 0;
    int          bad = 0;

    assign rf_data_a = rf_mem[rf_addr_a];
    assign rf_data_b = rf_mem[rf_addr_b];

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_skip    (in_skip),
        .in_sig     (in_sig),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_we      (in_we),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .rf_addr_a  (rf_addr_a),
        .rf_addr_b  (rf_addr_b),
        .rf_data_a  (rf_data_a),
        .rf_data_b  (rf_data_b),
        .ex_we      (ex_we),
        .ex_rd      (ex_rd),
        .ex_data    (ex_data),
        .ex_pending (ex_pending),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_skip   (alu_skip),
        .alu_sig    (alu_sig),
        .out_rd     (out_rd),
        .out_we     (out_we)
    );

    task automatic chk(string name, logic [74:0] act,
                       logic [74:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic exp_t dut_out();
        dut_out = '{alu_a, alu_b, alu_opcode, alu_skip,
                    alu_sig, out_rd, out_we};
    endfunction

    // Architectural view seen by the issuing instruction: bank
    // contents overlaid by WB, then by the younger EX result.
    function automatic exp_t model();
        logic [31:0] view [16];
        exp_t e;
        for (int i = 0; i < 16; i++) view[i] = rf_mem[i];
        if (wb_we) view[wb_rd] = wb_data;
        if (ex_we) view[ex_rd] = ex_data;
        view[0] = '0;
        e.a    = view[in_rs1];
        e.b    = in_use_imm ? in_imm : view[in_rs2];
        e.op   = in_opcode;
        e.skip = in_skip;
        e.sig  = in_sig;
        e.rd   = in_rd;
        e.we   = in_we;
        return e;
    endfunction

    function automatic bit model_stall();
        bit load_busy;
        load_busy = ex_we && ex_pending && ex_rd != 4'd0;
        return in_valid && load_busy
            && ((!in_skip && in_rs1 == ex_rd)
             || (!in_use_imm && in_rs2 == ex_rd));
    endfunction

    // Stimulus side: note accepts and drops, push on the edge.
    bit   acc = 0;
    bit   drop = 0;
    exp_t pend;

    always @(negedge clk) begin
        acc  = !reset && in_valid && in_ready;
        drop = !reset && flush && out_valid && !out_ready;
        pend = model();
        if (!reset)
            chk("in_ready", {74'd0, in_ready},
                {74'd0, !flush && !model_stall()
                        && (q.size() == 0 || out_ready)});
    end

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
        end else begin
            if (drop && q.size() > 0) void'(q.pop_front());
            if (acc) q.push_back(pend);
        end
    end

    // Monitor: compare each consumed output, watch stalls.
    bit   hold_chk = 0;
    exp_t snap;

    always @(negedge clk) begin
        if (reset) begin
            hold_chk = 0;
        end else begin
            chk("out_valid", {74'd0, out_valid},
                {74'd0, q.size() != 0});
            if (hold_chk)
                chk("stall_stable", dut_out(), snap);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 75'd1, 75'd0);
                end else begin
                    chk("alu_out", dut_out(), q.pop_front());
                end
            end
            hold_chk = out_valid && !out_ready && !flush;
            snap = dut_out();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid   = 0;
        flush      = 0;
        ex_we      = 0;
        ex_pending = 0;
        wb_we      = 0;
        in_use_imm = 0;
        in_skip    = 0;
        in_sig     = 0;
        out_ready  = 1;
    endtask

    task automatic rand_in();
        in_valid   = $urandom_range(0, 9) < 7;
        in_opcode  = 4'($urandom_range(0, 8));
        in_skip    = $urandom_range(0, 3) == 0;
        in_sig     = 1'($urandom);
        in_rs1     = 4'($urandom_range(0, 7));
        in_rs2     = 4'($urandom_range(0, 7));
        in_rd      = 4'($urandom);
        in_we      = 1'($urandom);
        in_use_imm = $urandom_range(0, 3) == 0;
        in_imm     = $urandom;
        ex_we      = 1'($urandom);
        ex_rd      = 4'($urandom_range(0, 7));
        ex_data    = $urandom;
        ex_pending = $urandom_range(0, 4) == 0;
        wb_we      = 1'($urandom);
        wb_rd      = 4'($urandom_range(0, 7));
        wb_data    = $urandom;
        out_ready  = $urandom_range(0, 9) < 7;
        flush      = $urandom_range(0, 19) == 0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf_mem[i] = $urandom;
        rf_mem[2] = 32'd5;
        rf_mem[3] = 32'd7;
        rf_mem[4] = 32'h11;
        idle();
        reset = 1;
        tick();
        tick();
        chk("rst_valid", {74'd0, out_valid}, 75'd0);
        chk("rst_data", dut_out(), 75'd0);
        reset = 0;

        // plain ADD from the bank
        in_valid = 1; in_opcode = 4'd3;
        in_rs1 = 4'd2; in_rs2 = 4'd3;
        tick();
        chk("add_valid", {74'd0, out_valid}, 75'd1);
        chk("add_a", {43'd0, alu_a}, 75'd5);
        chk("add_b", {43'd0, alu_b}, 75'd7);
        chk("add_op", {71'd0, alu_opcode}, 75'd3);

        // EX beats WB beats bank
        in_rs1 = 4'd4; in_rs2 = 4'd0;
        ex_we = 1; ex_rd = 4'd4; ex_data = 32'hAA;
        wb_we = 1; wb_rd = 4'd4; wb_data = 32'hBB;
        tick();
        chk("fwd_ex", {43'd0, alu_a}, 75'hAA);
        ex_we = 0;
        tick();
        chk("fwd_wb", {43'd0, alu_a}, 75'hBB);

        // r0 never forwarded; immediate bypasses forwarding
        wb_we = 0; ex_we = 1; ex_rd = 4'd0;
        ex_data = 32'hFF; in_rs1 = 4'd0;
        tick();
        chk("r0_zero", {43'd0, alu_a}, 75'd0);
        in_rs1 = 4'd2; in_rs2 = 4'd5; ex_rd = 4'd5;
        in_use_imm = 1; in_imm = 32'h1234;
        tick();
        chk("imm_b", {43'd0, alu_b}, 75'h1234);

        // load-use stall on rs2
        in_use_imm = 0; ex_rd = 4'd3; ex_pending = 1;
        in_rs2 = 4'd3;
        #1;
        chk("lu_ready", {74'd0, in_ready}, 75'd0);
        tick();
        chk("lu_bubble", {74'd0, out_valid}, 75'd0);
        ex_pending = 0; ex_data = 32'd9;
        #1;
        chk("lu_release", {74'd0, in_ready}, 75'd1);
        tick();
        chk("lu_b", {43'd0, alu_b}, 75'd9);
        ex_pending = 1; in_use_imm = 1;
        #1;
        chk("lu_imm_nostall", {74'd0, in_ready}, 75'd1);
        tick();
        idle();

        // downstream stall with toggling inputs
        in_valid = 1; in_opcode = 4'd4;
        in_rs1 = 4'd2; in_rs2 = 4'd3;
        tick();
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_rs1 = 4'($urandom); in_rs2 = 4'($urandom);
            in_opcode = 4'($urandom); in_imm = $urandom;
            #1;
            chk("stall_ready", {74'd0, in_ready}, 75'd0);
            tick();
            chk("stall_a", {43'd0, alu_a}, 75'd5);
            chk("stall_op", {71'd0, alu_opcode}, 75'd4);
        end
        in_rs1 = 4'd3; in_rs2 = 4'd2; in_opcode = 4'd2;
        out_ready = 1;
        #1;
        chk("unstall_ready", {74'd0, in_ready}, 75'd1);
        tick();
        chk("unstall_a", {43'd0, alu_a}, 75'd7);
        chk("unstall_b", {43'd0, alu_b}, 75'd5);

        // flush while stalled downstream
        in_valid = 0; out_ready = 0;
        tick();
        chk("fl_held", {74'd0, out_valid}, 75'd1);
        flush = 1; in_valid = 1;
        #1;
        chk("fl_ready", {74'd0, in_ready}, 75'd0);
        tick();
        flush = 0; in_valid = 0;
        chk("fl_drop", {74'd0, out_valid}, 75'd0);

        // reset mid-stall
        out_ready = 1; in_valid = 1;
        tick();
        in_valid = 0; out_ready = 0;
        tick();
        reset = 1;
        tick();
        reset = 0;
        chk("rst2_valid", {74'd0, out_valid}, 75'd0);
        chk("rst2_ab", {11'd0, alu_a, alu_b}, 75'd0);

        repeat (3000) begin
            rand_in();
            if ($urandom_range(0, 9) == 0)
                rf_mem[$urandom_range(1, 15)] = $urandom;
            tick();
        end

        idle();
        repeat (5) tick();
        chk("drain", {43'd0, 32'(q.size())}, 75'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Issue stage directly upstream of the combinational ALU.
- Accepts a decoded instruction and reads the register bank.
- Resolves operands using forwarding from the execute-result and writeback stages, detects load-use hazards, and inserts bubbles.
- Registers a, b, opcode, skip and sig for the ALU. Valid/ready handshake on both sides; synchronous flush.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 4, register address width (16 registers; r0 reads as zero).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  squash the held instruction and refuse new input this cycle.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts it this cycle (combinational).
- in_opcode  in  4  ALU opcode.
- in_skip  in  1  pass b through; a unused.
- in_sig  in  1  signed compare.
- in_rs1  in  REG_AW  source register for a.
- in_rs2  in  REG_AW  source register for b.
- in_rd  in  REG_AW  destination register.
- in_we  in  1  instruction writes rd.
- in_use_imm  in  1  b = in_imm instead of rs2.
- in_imm  in  DATA_W  immediate.
- rf_addr_a  out  REG_AW  register bank read address A, combinationally equal to in_rs1.
- rf_addr_b  out  REG_AW  register bank read address B, combinationally equal to in_rs2.
- rf_data_a  in  DATA_W  same-cycle read data for port A.
- rf_data_b  in  DATA_W  same-cycle read data for port B.
- ex_we  in  1  stage after ALU will write ex_rd.
- ex_rd  in  REG_AW  its destination register.
- ex_data  in  DATA_W  its result.
- ex_pending  in  1  ex_data not yet valid (load in flight).
- wb_we  in  1  writeback stage writes wb_rd.
- wb_rd  in  REG_AW  writeback destination register.
- wb_data  in  DATA_W  writeback data.
- out_valid  out  1  ALU inputs valid.
- out_ready  in  1  downstream consumes.
- alu_a  out  DATA_W  ALU operand a.
- alu_b  out  DATA_W  ALU operand b.
- alu_opcode  out  4  ALU opcode.
- alu_skip  out  1  ALU skip.
- alu_sig  out  1  ALU signed compare.
- out_rd  out  REG_AW  destination carried forward.
- out_we  out  1  write enable carried forward.

Behaviour:
- Reset: out_valid=0 and all registered outputs=0 on the first clk edge with reset high. Reset overrides flush and load.
- need_a = !in_skip. need_b = !in_use_imm.
- Operand resolve, per source register, priority order:
  - src==0 -> 0.
  - ex_we && ex_rd==src -> ex_data.
  - wb_we && wb_rd==src -> wb_data.
  - otherwise rf_data.
- Writes to r0 are never forwarded.
- b = in_use_imm ? in_imm : resolved rs2.
- hazard = in_valid && ex_we && ex_pending && ex_rd!=0 && ((need_a && ex_rd==in_rs1) || (need_b && ex_rd==in_rs2)).
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Per-cycle priority on the clk edge:
  - reset.
  - flush -> out_valid<=0.
  - in_valid && in_ready -> load all outputs; out_valid<=1.
  - out_ready (or !out_valid) -> out_valid<=0; bubble, data fields hold.
  - otherwise hold all outputs unchanged (stall).
- Latency: exactly 1 cycle from accept to out_valid.
- Throughput: 1 instruction/cycle with out_ready held high and no hazards.
- While out_valid && !out_ready, every output stays bit-stable regardless of input changes.
- A hazard lasts until ex_pending drops or the EX instruction retires. Each stalled cycle with a free output slot inserts one bubble.
- in_valid=0: rf_addr outputs still track inputs; no state change except bubble/drain.
- Flush while stalled downstream: the held instruction is dropped (out_valid<=0) even if out_ready=0.

Decomposition:
- Shared package holds:
  - ALU opcode constants: OR=0, AND=1, XOR=2, ADD=3, SUB=4, SHIFTL=5, SHIFTR=6, MULT=7, NOTA=8.
  - DATA_W, REG_AW.
  - Register-zero constant.
  - The ALU and this stage both import them.
- One sub-module, operand_fwd_mux: combinational resolve for a single source, instantiated twice.

Test Plan:
- Plain ADD, rs1=r2 (rf 5), rs2=r3 (rf 7), no forwards -> next cycle out_valid=1, alu_a=5, alu_b=7, alu_opcode=3.
- rs1=r4, ex_we=1, ex_rd=4, ex_data=0xAA, wb_we=1, wb_rd=4, wb_data=0xBB, rf=0x11 -> alu_a=0xAA. Same case with ex_we=0 -> alu_a=0xBB.
- rs1=r0, ex_we=1, ex_rd=0, ex_data=0xFF -> alu_a=0. in_use_imm=1, in_imm=0x1234, rs2 matches ex_rd -> alu_b=0x1234, no forward.
- Load-use: ex_pending=1, ex_rd=3, in_rs2=3, in_use_imm=0 -> in_ready=0, one bubble (out_valid=0). After ex_pending drops with ex_data=9 -> accepted, alu_b=9. Same case with in_use_imm=1 -> no stall.
- out_ready=0 for 3 cycles after a load while inputs toggle -> outputs bit-stable, in_ready=0. out_ready=1 -> next instruction loaded the following cycle.
- Flush with out_valid=1, out_ready=0 -> out_valid=0 next cycle, in_ready=0 during flush. Reset asserted mid-stall -> out_valid=0 and alu_a=alu_b=0 after one edge.
